// File: rtl/stream_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | stream_pkg: shared mode constants and slice helper for stream  |
// | merge blocks.                          Revision: 1.0           |
// +----------------------------------------------------------------+
package stream_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  function automatic int slice_lsb(input int idx, input int size);
    return idx * size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------+
// | rr_arbiter: combinational round-robin pick, searching upward   |
// | from last+1 with wrap.                 Revision: 1.0           |
// +----------------------------------------------------------------+
module rr_arbiter
  import stream_pkg::*;
#(
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] last,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_idx
);

  logic [SEL_W-1:0] idx;

  // Walk from farthest to nearest so the closest requester after last wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int k = N; k >= 1; k--) begin
      idx = SEL_W'((int'(last) + k) % N);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_muxn.sv
`default_nettype none
// +----------------------------------------------------------------+
// | stream_muxn: N-to-1 registered valid/ready stream merge with   |
// | external select or round-robin grant.  Revision: 1.0           |
// +----------------------------------------------------------------+
module stream_muxn
  import stream_pkg::*;
#(
  parameter  int SIZE  = 32,
  parameter  int N     = 4,
  parameter  int MODE  = MODE_SEL,
  localparam int SEL_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*SIZE-1:0] in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  input  logic [SEL_W-1:0]  s,
  output logic [SIZE-1:0]   out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SEL_W-1:0]  out_chan
);

  logic             out_valid_q, out_valid_d;
  logic [SIZE-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic             load_en;
  logic             gnt_valid;
  logic [SEL_W-1:0] gnt_idx;
  logic [SIZE-1:0]  gnt_data;

  assign load_en = ~out_valid_q | out_ready;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [SEL_W-1:0] rr_last_q, rr_last_d;
      logic             unused_s;

      assign unused_s = ^s;

      rr_arbiter #(.N(N)) u_arb (
        .req       (in_valid),
        .last      (rr_last_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
      );

      // Pointer moves only on a real transfer so stalls keep priority intact.
      always_comb begin
        rr_last_d = rr_last_q;
        if (gnt_valid && load_en) rr_last_d = gnt_idx;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_last_q <= SEL_W'(N - 1);
        else     rr_last_q <= rr_last_d;
      end
    end else begin : g_sel
      // An out-of-range select matches no channel and so never grants.
      always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = s;
        for (int i = 0; i < N; i++) begin
          if (s == SEL_W'(i) && in_valid[i]) gnt_valid = 1'b1;
        end
      end
    end
  endgenerate

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SEL_W'(i)) gnt_data = in_data[slice_lsb(i, SIZE) +: SIZE];
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = ~rst & load_en & gnt_valid & (gnt_idx == SEL_W'(i));
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (load_en && gnt_valid) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
      out_chan_d  = gnt_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_muxn.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_stream_muxn: directed bench for select (N=3) and round-robin |
// | (N=4) instances with a transaction-level reference model.       |
// | Revision: 1.0                                                    |
// +----------------------------------------------------------------+
module tb_stream_muxn;

  logic         clk = 1'b0;
  logic         rst;

  logic [95:0]  id_s;
  logic [2:0]   iv_s, rdy_s;
  logic [1:0]   s_s, ch_s;
  logic [31:0]  od_s;
  logic         ov_s, or_s;

  logic [127:0] id_r;
  logic [3:0]   iv_r, rdy_r;
  logic [1:0]   s_r, ch_r;
  logic [31:0]  od_r;
  logic         ov_r, or_r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_muxn #(.SIZE(32), .N(3), .MODE(0)) dut_sel (
    .clk(clk), .rst(rst), .in_data(id_s), .in_valid(iv_s), .in_ready(rdy_s),
    .s(s_s), .out_data(od_s), .out_valid(ov_s), .out_ready(or_s), .out_chan(ch_s)
  );

  stream_muxn #(.SIZE(32), .N(4), .MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .in_data(id_r), .in_valid(iv_r), .in_ready(rdy_r),
    .s(s_r), .out_data(od_r), .out_valid(ov_r), .out_ready(or_r), .out_chan(ch_r)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: register contents after the next edge, from the protocol rules.
  bit          mv_s, mv_r;
  logic [31:0] md_s, md_r;
  int          mc_s, mc_r, mptr, sel, win;
  logic [2:0]  e_rdy_s;
  logic [3:0]  e_rdy_r;

  initial begin
    mv_s = 0; md_s = 0; mc_s = 0;
    mv_r = 0; md_r = 0; mc_r = 0; mptr = 3;
    forever begin
      @(negedge clk);
      if (rst) begin
        mv_s = 0; md_s = 0; mc_s = 0;
        mv_r = 0; md_r = 0; mc_r = 0; mptr = 3;
      end
      chk("m_sel_valid", ov_s, mv_s);
      chk("m_sel_data", od_s, md_s);
      chk("m_sel_chan", ch_s, mc_s);
      chk("m_rr_valid", ov_r, mv_r);
      chk("m_rr_data", od_r, md_r);
      chk("m_rr_chan", ch_r, mc_r);

      e_rdy_s = '0;
      sel = int'(s_s);
      if (!rst && (!mv_s || or_s) && sel < 3) begin
        if (iv_s[sel]) e_rdy_s[sel] = 1'b1;
      end
      chk("m_sel_ready", rdy_s, e_rdy_s);
      if (e_rdy_s != 0) begin
        mv_s = 1; md_s = id_s[sel*32 +: 32]; mc_s = sel;
      end else if (or_s) begin
        mv_s = 0;
      end

      win = -1;
      if (!rst && (!mv_r || or_r)) begin
        for (int k = 1; k <= 4; k++) begin
          if (win < 0 && iv_r[(mptr + k) % 4]) win = (mptr + k) % 4;
        end
      end
      e_rdy_r = '0;
      if (win >= 0) e_rdy_r[win] = 1'b1;
      chk("m_rr_ready", rdy_r, e_rdy_r);
      if (win >= 0) begin
        mv_r = 1; md_r = id_r[win*32 +: 32]; mc_r = win; mptr = win;
      end else if (or_r) begin
        mv_r = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1; id_s = '0; iv_s = '0; s_s = '0; or_s = 0;
    id_r = '0; iv_r = '0; s_r = '0; or_r = 0;
    repeat (2) @(posedge clk);
    #2 rst = 0;

    // Select mode: channel 2, then out-of-range select drains.
    id_s = {32'h0000_0022, 32'h0000_0011, 32'h0000_000A};
    s_s = 2; iv_s = 3'b111; or_s = 1;
    #1 chk("sel_rdy_s2", rdy_s, 3'b100);
    @(posedge clk); #1;
    chk("sel_data_22", od_s, 32'h22);
    chk("sel_chan_2", ch_s, 2);
    chk("sel_valid_1", ov_s, 1);
    #1 s_s = 3;
    #1 chk("sel_rdy_oor", rdy_s, 3'b000);
    @(posedge clk); #1 chk("sel_drain_oor", ov_s, 0);

    // Backpressure with select churn, then drain+load on one edge.
    #1 s_s = 1; id_s[63:32] = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    chk("bp_load", od_s, 32'hA5A5_A5A5);
    chk("bp_chan", ch_s, 1);
    #1 or_s = 0;
    for (int i = 0; i < 4; i++) begin
      s_s = 2'(i); id_s[63:32] = 32'h1000 + i;
      #1 chk("bp_rdy_stall", rdy_s, 3'b000);
      @(posedge clk); #1;
      chk("bp_hold_data", od_s, 32'hA5A5_A5A5);
      chk("bp_hold_valid", ov_s, 1);
      #1;
    end
    or_s = 1; s_s = 1; id_s[63:32] = 32'h5A5A_5A5A;
    #1 chk("bp_rdy_release", rdy_s, 3'b010);
    @(posedge clk); #1;
    chk("bp_reload", od_s, 32'h5A5A_5A5A);
    chk("bp_reload_valid", ov_s, 1);
    #1 iv_s = '0;
    @(posedge clk); #1 chk("bp_drain", ov_s, 0);

    // Asynchronous reset with a held word.
    #1 iv_s = 3'b001; s_s = 0; id_s[31:0] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("rst_pre_data", od_s, 32'hDEAD_BEEF);
    chk("rst_pre_valid", ov_s, 1);
    #1 or_s = 0; rst = 1;
    #1;
    chk("rst_async_valid", ov_s, 0);
    chk("rst_async_data", od_s, 0);
    chk("rst_async_chan", ch_s, 0);
    chk("rst_rdy", rdy_s, 3'b000);
    @(posedge clk); #2 rst = 0; iv_s = '0;

    // Round-robin fairness with all channels valid.
    id_r = {32'h103, 32'h102, 32'h101, 32'h100};
    iv_r = 4'hF; or_r = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("rr_seq_chan", ch_r, i % 4);
      chk("rr_seq_data", od_r, 32'h100 + (i % 4));
      chk("rr_seq_valid", ov_r, 1);
    end
    #1 iv_r = '0;
    repeat (2) @(posedge clk);

    // Round-robin skip and stall.
    #2 iv_r = 4'b1010;
    #1 chk("rr_skip_rdy1", rdy_r, 4'b0010);
    @(posedge clk); #1 chk("rr_skip_chan1", ch_r, 1);
    #1 or_r = 0;
    #1 chk("rr_stall_rdy", rdy_r, 4'b0000);
    @(posedge clk); #1;
    chk("rr_stall_chan", ch_r, 1);
    chk("rr_stall_data", od_r, 32'h101);
    #1 or_r = 1;
    #1 chk("rr_skip_rdy3", rdy_r, 4'b1000);
    @(posedge clk); #1;
    chk("rr_skip_chan3", ch_r, 3);
    chk("rr_skip_data3", od_r, 32'h103);
    #1 iv_r = '0;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_muxn.md
Name: stream_muxn

Overview:
- Parametrised N-input, 1-output registered stream multiplexer with valid/ready handshakes on every channel.
- Two modes:
  - Select mode: an external select picks the input channel.
  - Round-robin mode: a fair internal arbiter picks the channel.
- Sits between pipeline stages and multi-source producers, e.g. writeback source merge and memory-request merge.
- Replaces the fixed 2:1 and 3:1 combinational selectors wherever a registered, stallable merge is needed.

Parameters:
- SIZE, 32, data width per channel in bits.
- N, 4, number of input channels; legal range 2..16.
- MODE, 0, 0 = select mode (input s chooses the channel), 1 = round-robin arbitration (s ignored).
- SEL_W, $clog2(N), localparam derived from N; not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  N*SIZE  packed channel data; channel i occupies bits [i*SIZE +: SIZE].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready; at most one bit high per cycle.
- s  in  SEL_W  channel select; used only when MODE=0.
- out_data  out  SIZE  registered output data.
- out_valid  out  1  registered output valid.
- out_ready  in  1  downstream ready.
- out_chan  out  SEL_W  index of the channel whose data sits in the output register.

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer rr_last=N-1, so channel 0 has first priority after reset.
- Reset is asynchronous: asserting rst mid-transfer clears the output register immediately, and any held word is dropped.
- While rst is high, in_ready must be 0.
- Load enable: load_en = ~out_valid | out_ready (the output register is empty or draining this cycle).
- Grant in select mode (MODE=0):
  - Candidate channel is s.
  - If s >= N, no channel is granted and all in_ready are 0. This is the out-of-range case, analogous to the old 3:1 selector's code 11.
  - Grant asserts only if in_valid[s]=1.
- Grant in round-robin mode (MODE=1):
  - Search channels starting at rr_last+1, wrapping modulo N; the first channel with in_valid=1 wins.
  - rr_last updates to the winner only on an actual transfer (grant & load_en).
  - Stalled cycles do not advance the pointer.
- in_ready[i] = load_en & (grant index == i) & grant valid. This path is combinational from out_ready, in_valid and s.
- There is no combinational path from any input to out_valid, out_data or out_chan.
- Transfer in: when in_valid[g] & in_ready[g], the next edge captures out_data<=in_data[g], out_chan<=g, out_valid<=1.
- Transfer out: when out_valid & out_ready and no new load occurs, the next edge sets out_valid<=0. out_data and out_chan hold their last values and are not cleared.
- Simultaneous drain and load in one cycle: the output register is replaced.
  - Full throughput: one word per cycle sustained.
  - Latency: input accepted on cycle t appears on out_data at cycle t+1.
- Stall: while out_valid=1 & out_ready=0, out_data, out_chan and out_valid are held stable and all in_ready are 0. Changes to s or in_valid during a stall have no effect on the held word.
- Producers must hold in_data/in_valid stable until accepted; this is a protocol rule, not checked by the block.
- Fairness (MODE=1): with all channels continuously valid and out_ready=1, grants cycle 0,1,...,N-1,0,... with no channel starved more than N-1 transfers.

Decomposition:
- Shared package stream_pkg:
  - Constants MODE_SEL=0, MODE_RR=1.
  - A function for the packed-slice index (i*SIZE).
- One sub-module: rr_arbiter.
  - Parameter N.
  - Inputs: req[N], last[SEL_W].
  - Outputs: gnt_valid, gnt_idx[SEL_W].
  - Purely combinational; the rr_last register stays in stream_muxn.
  - Instantiate rr_arbiter only under MODE=1 via generate.

Test Plan:
- Reset: assert rst mid-stream with out_valid=1 and data 0xDEADBEEF held -> out_valid=0, out_data=0, out_chan=0 asynchronously, before the next clk edge; in_ready=0 while rst is high.
- Select mode, N=3, s=2, in_valid=3'b111, in_data ch2=0x00000022, out_ready=1 -> in_ready=3'b100; next cycle out_data=0x22, out_chan=2, out_valid=1. Set s=3 (out of range) -> in_ready=0 and out_valid falls to 0 after the drain.
- Backpressure, MODE=0, s=1: load 0xA5A5A5A5, then hold out_ready=0 for 4 cycles while changing s and ch1 data -> out_data stays 0xA5A5A5A5, in_ready=0 throughout; release out_ready -> new word loads on the same edge that drains.
- Round-robin, N=4, all in_valid=1, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3, one word per cycle.
- Round-robin skip/stall: in_valid=4'b1010, out_ready toggling 1,0,1 -> grants 1 then 3; rr_last is unchanged across the stalled cycle; no grant to channels 0 or 2.
